// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// datapath select codes, FSM states and instruction classes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALU operation codes, shared with the ALU.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_DM   = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_WB     = 3'd5,
        S_BR     = 3'd6,
        S_JMP    = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_NOP  = 4'd0,
        C_ADDU = 4'd1,
        C_SUBU = 4'd2,
        C_ORI  = 4'd3,
        C_LUI  = 4'd4,
        C_LW   = 4'd5,
        C_SW   = 4'd6,
        C_BEQ  = 4'd7,
        C_J    = 4'd8,
        C_JAL  = 4'd9,
        C_JR   = 4'd10
    } cls_e;

    // Classes that travel DECODE -> EXE.
    function automatic logic is_exe_class(input cls_e c);
        return (c == C_ADDU) || (c == C_SUBU) || (c == C_ORI) ||
               (c == C_LUI)  || (c == C_LW)   || (c == C_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct classifier; unknown encodings map to NOP.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_e       cls
);

    always_comb begin
        cls = C_NOP;
        unique case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = C_ADDU;
                    FN_SUBU: cls = C_SUBU;
                    FN_JR:   cls = C_JR;
                    default: cls = C_NOP;
                endcase
            end
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: state register, latched instruction class
// and a Moore output decode (only the branch PCWr looks at zero).
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] ALUOp,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] RegDst,
    output logic       ALUSrcB,
    output logic [1:0] ExtOp,
    output logic [1:0] MemToReg,
    output logic [1:0] NPCOp,
    output logic [2:0] state
);

    state_e state_q, state_d;
    cls_e   cls_q, cls_d, dec_cls;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // DECODE routes on the live classifier; later states use the latched class.
    always_comb begin
        state_d = S_FETCH;
        cls_d   = cls_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                cls_d = dec_cls;
                if (is_exe_class(dec_cls))
                    state_d = S_EXE;
                else if (dec_cls == C_BEQ)
                    state_d = S_BR;
                else if (dec_cls == C_J || dec_cls == C_JAL || dec_cls == C_JR)
                    state_d = S_JMP;
                else
                    state_d = S_FETCH;
            end
            S_EXE: begin
                if (cls_q == C_LW)
                    state_d = S_MEMRD;
                else if (cls_q == C_SW)
                    state_d = S_MEMWR;
                else
                    state_d = S_WB;
            end
            S_MEMRD:  state_d = S_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUOp    = ALU_ADD;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        RegDst   = RD_RT;
        ALUSrcB  = 1'b0;
        ExtOp    = EXT_ZERO;
        MemToReg = M2R_ALU;
        NPCOp    = NPC_PC4;
        case (state_q)
            S_FETCH: begin
                IRWr = 1'b1;
                PCWr = 1'b1;
            end
            S_EXE, S_MEMWR: begin
                MemWr = (state_q == S_MEMWR);
                case (cls_q)
                    C_SUBU: ALUOp = ALU_SUB;
                    C_ORI: begin
                        ALUOp   = ALU_OR;
                        ALUSrcB = 1'b1;
                    end
                    C_LUI: begin
                        ALUOp   = ALU_OR;
                        ALUSrcB = 1'b1;
                        ExtOp   = EXT_LUI;
                    end
                    C_LW, C_SW: begin
                        ALUSrcB = 1'b1;
                        ExtOp   = EXT_SIGN;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                case (cls_q)
                    C_ADDU, C_SUBU: begin
                        RegWr  = 1'b1;
                        RegDst = RD_RD;
                    end
                    C_ORI, C_LUI: RegWr = 1'b1;
                    C_LW: begin
                        RegWr    = 1'b1;
                        MemToReg = M2R_DM;
                    end
                    default: ;
                endcase
            end
            S_BR: begin
                ALUOp = ALU_SUB;
                NPCOp = NPC_BR;
                PCWr  = zero;
            end
            S_JMP: begin
                case (cls_q)
                    C_J: begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_J;
                    end
                    C_JAL: begin
                        PCWr     = 1'b1;
                        NPCOp    = NPC_J;
                        RegWr    = 1'b1;
                        RegDst   = RD_RA;
                        MemToReg = M2R_PC;
                    end
                    C_JR: begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_JR;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Reset aborts any write in flight, whatever the state.
        if (reset) begin
            PCWr  = 1'b0;
            IRWr  = 1'b0;
            RegWr = 1'b0;
            MemWr = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: checks every output and the state once per cycle.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] ALUOp;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrcB;
    logic [1:0] RegDst, ExtOp, MemToReg, NPCOp;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .ALUOp    (ALUOp),
        .PCWr     (PCWr),
        .IRWr     (IRWr),
        .RegWr    (RegWr),
        .MemWr    (MemWr),
        .RegDst   (RegDst),
        .ALUSrcB  (ALUSrcB),
        .ExtOp    (ExtOp),
        .MemToReg (MemToReg),
        .NPCOp    (NPCOp),
        .state    (state)
    );

    // Packed expected vector:
    // {state, ALUOp, PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrcB, ExtOp, MemToReg, NPCOp}
    function automatic logic [18:0] ev(input logic [2:0] st, input logic [2:0] alu,
                                       input logic pc, input logic ir, input logic rw,
                                       input logic mw, input logic [1:0] rd, input logic bs,
                                       input logic [1:0] ext, input logic [1:0] m2r,
                                       input logic [1:0] npc);
        return {st, alu, pc, ir, rw, mw, rd, bs, ext, m2r, npc};
    endfunction

    wire [18:0] obs = {state, ALUOp, PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrcB,
                       ExtOp, MemToReg, NPCOp};

    // Check the current cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [18:0] exp);
        #1;
        tests_run++;
        assert (obs === exp)
            $display("[TB] %-12s st=%0d obs=%b ok", tag, state, obs);
        else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    logic [18:0] FE, DE, ZR;
    logic [18:0] R_WB, I_WB, LS_EX;

    initial begin
        FE    = ev(3'd0, 3'b000, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        DE    = ev(3'd1, 3'b000, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        ZR    = '0;
        R_WB  = ev(3'd5, 3'b000, 0, 0, 1, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
        I_WB  = ev(3'd5, 3'b000, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        LS_EX = ev(3'd2, 3'b000, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 2'b00);

        reset = 1'b1;
        zero  = 1'b0;
        set_instr(6'b101011, 6'b000000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc("rst_init", ZR);
        reset = 1'b0;

        // sw up to MEMWR, then reset for two edges.
        cyc("sw0_fe", FE);
        cyc("sw0_de", DE);
        cyc("sw0_ex", LS_EX);
        reset = 1'b1;
        cyc("rst_memwr", ev(3'd4, 3'b000, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 2'b00));
        cyc("rst_hold", ZR);
        reset = 1'b0;

        // addu, subu, ori, lui
        set_instr(6'b000000, 6'b100001);
        cyc("addu_fe", FE);
        cyc("addu_de", DE);
        cyc("addu_ex", ev(3'd2, 3'b000, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00));
        cyc("addu_wb", R_WB);
        set_instr(6'b000000, 6'b100011);
        cyc("subu_fe", FE);
        cyc("subu_de", DE);
        set_instr(6'b111111, 6'b111111);  // class must already be latched
        cyc("subu_ex", ev(3'd2, 3'b001, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00));
        cyc("subu_wb", R_WB);
        set_instr(6'b001101, 6'b000000);
        cyc("ori_fe", FE);
        cyc("ori_de", DE);
        cyc("ori_ex", ev(3'd2, 3'b010, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00));
        cyc("ori_wb", I_WB);
        set_instr(6'b001111, 6'b000000);
        cyc("lui_fe", FE);
        cyc("lui_de", DE);
        cyc("lui_ex", ev(3'd2, 3'b010, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 2'b00));
        cyc("lui_wb", I_WB);

        // lw then sw
        set_instr(6'b100011, 6'b000000);
        cyc("lw_fe", FE);
        cyc("lw_de", DE);
        cyc("lw_ex", LS_EX);
        cyc("lw_memrd", ev(3'd3, 3'b000, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00));
        cyc("lw_wb", ev(3'd5, 3'b000, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00));
        set_instr(6'b101011, 6'b000000);
        cyc("sw_fe", FE);
        cyc("sw_de", DE);
        cyc("sw_ex", LS_EX);
        cyc("sw_memwr", ev(3'd4, 3'b000, 0, 0, 0, 1, 2'b00, 1, 2'b01, 2'b00, 2'b00));

        // beq taken, beq not taken, addu with zero high
        set_instr(6'b000100, 6'b000000);
        cyc("beq1_fe", FE);
        cyc("beq1_de", DE);
        zero = 1'b1;
        cyc("beq1_br", ev(3'd6, 3'b001, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01));
        zero = 1'b0;
        cyc("beq2_fe", FE);
        cyc("beq2_de", DE);
        cyc("beq2_br", ev(3'd6, 3'b001, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01));
        set_instr(6'b000000, 6'b100001);
        zero = 1'b1;
        cyc("addz_fe", FE);
        cyc("addz_de", DE);
        cyc("addz_ex", ev(3'd2, 3'b000, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00));
        cyc("addz_wb", R_WB);
        zero = 1'b0;

        // jal, jr, j
        set_instr(6'b000011, 6'b000000);
        cyc("jal_fe", FE);
        cyc("jal_de", DE);
        cyc("jal_jmp", ev(3'd7, 3'b000, 1, 0, 1, 0, 2'b10, 0, 2'b00, 2'b10, 2'b10));
        set_instr(6'b000000, 6'b001000);
        cyc("jr_fe", FE);
        cyc("jr_de", DE);
        cyc("jr_jmp", ev(3'd7, 3'b000, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11));
        set_instr(6'b000010, 6'b000000);
        cyc("j_fe", FE);
        cyc("j_de", DE);
        cyc("j_jmp", ev(3'd7, 3'b000, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10));

        // nop (all zero), illegal opcode, then a normal fetch
        set_instr(6'b000000, 6'b000000);
        cyc("nop_fe", FE);
        cyc("nop_de", DE);
        set_instr(6'b111111, 6'b000000);
        cyc("ill_fe", FE);
        cyc("ill_de", DE);
        set_instr(6'b001101, 6'b000000);
        cyc("after_fe", FE);
        cyc("after_de", DE);
        cyc("after_ex", ev(3'd2, 3'b010, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
